// File: rtl/intr_ctrl.sv
// Fixed-priority interrupt controller. It captures request edges, picks the lowest eligible
// index and takes over the datapath for one cycle to vector the PC and push the return address.
module intr_ctrl #(
   parameter int unsigned     N_IRQ    = 4,
   parameter int unsigned     PC_W     = 10,
   parameter logic [PC_W-1:0] VEC_BASE = 10'h3F0
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic [N_IRQ-1:0] i_irq,
   input  logic             i_ei,
   input  logic             i_di,
   input  logic             i_reti,
   input  logic             i_hold,
   input  logic             i_mask_we,
   input  logic [N_IRQ-1:0] i_mask_wdata,
   output logic             o_take_int,
   output logic [PC_W-1:0]  o_pc_vec,
   output logic             o_int_push,
   output logic             o_int_wesp,
   output logic [N_IRQ-1:0] o_iack,
   output logic             o_in_service,
   output logic [N_IRQ-1:0] o_pending
);

   localparam int unsigned ID_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ENTER   = 2'd1,
      ST_SERVICE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [N_IRQ-1:0] r_irq_q;
   logic [N_IRQ-1:0] r_pending;
   logic [N_IRQ-1:0] r_mask;
   logic             r_gie;
   logic [ID_W-1:0]  r_cur_id;
   logic [N_IRQ-1:0] w_rise;
   logic [N_IRQ-1:0] w_eligible;
   logic [N_IRQ-1:0] w_clr;
   logic [ID_W-1:0]  w_winner;
   logic             w_any;
   logic             w_take;

   // Vector of source id: VEC_BASE + 4*id, wrapped to the PC width.
   function automatic logic [PC_W-1:0] vec_addr(input logic [ID_W-1:0] id);
      logic [PC_W+ID_W+1:0] sum;
      sum = (PC_W+ID_W+2)'(VEC_BASE) + (PC_W+ID_W+2)'({id, 2'b00});
      return sum[PC_W-1:0];
   endfunction

   assign w_rise     = i_irq & ~r_irq_q;
   assign w_eligible = r_pending & ~r_mask;
   assign w_any      = |w_eligible;
   assign w_take     = (r_state == ST_IDLE) & r_gie & w_any & ~i_hold & ~i_reti;
   assign o_pending  = r_pending;

   // Priority pick: scanning downward leaves the lowest set index as the winner.
   always_comb begin
      w_winner = '0;
      for (int i = N_IRQ - 1; i >= 0; i--) begin
         if (w_eligible[i]) begin
            w_winner = ID_W'(i);
         end else begin
            w_winner = w_winner;
         end
      end
   end

   // Clear strobe for the winner's pending bit on the entry edge.
   always_comb begin
      w_clr = '0;
      for (int i = 0; i < N_IRQ; i++) begin
         w_clr[i] = w_take & (w_winner == ID_W'(i));
      end
   end

   // State register.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:    w_state_nxt = w_take ? ST_ENTER : ST_IDLE;
         ST_ENTER:   w_state_nxt = ST_SERVICE;
         ST_SERVICE: w_state_nxt = i_reti ? ST_IDLE : ST_SERVICE;
         default:    w_state_nxt = ST_IDLE;
      endcase
   end

   // Edge capture, pending bits (a new edge beats the entry clear), mask, gie and serviced id.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_irq_q   <= '0;
         r_pending <= '0;
         r_mask    <= '0;
         r_gie     <= 1'b0;
         r_cur_id  <= '0;
      end else begin
         r_irq_q   <= i_irq;
         r_pending <= (r_pending & ~w_clr) | w_rise;
         if (i_mask_we) begin
            r_mask <= i_mask_wdata;
         end else begin
            r_mask <= r_mask;
         end
         if (i_di) begin
            r_gie <= 1'b0;
         end else if (i_ei) begin
            r_gie <= 1'b1;
         end else begin
            r_gie <= r_gie;
         end
         if (w_take) begin
            r_cur_id <= w_winner;
         end else begin
            r_cur_id <= r_cur_id;
         end
      end
   end

   // Moore output decode from the state register and the serviced id.
   always_comb begin
      o_take_int   = 1'b0;
      o_pc_vec     = '0;
      o_int_push   = 1'b0;
      o_int_wesp   = 1'b0;
      o_iack       = '0;
      o_in_service = 1'b0;
      case (r_state)
         ST_ENTER: begin
            o_take_int   = 1'b1;
            o_pc_vec     = vec_addr(r_cur_id);
            o_int_push   = 1'b1;
            o_int_wesp   = 1'b1;
            o_in_service = 1'b1;
            for (int i = 0; i < N_IRQ; i++) begin
               o_iack[i] = (r_cur_id == ID_W'(i));
            end
         end
         ST_SERVICE: o_in_service = 1'b1;
         default:    o_in_service = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_intr_ctrl.sv
// Table-driven bench for intr_ctrl: each record holds one cycle of inputs and the outputs
// expected right after the edge that samples them; expectations pass through a scoreboard queue.
module tb_intr_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] irq;
   logic       ei, di, reti, hold, mask_we;
   logic [3:0] mask_wdata;
   logic       take_int, int_push, int_wesp, in_service;
   logic [9:0] pc_vec;
   logic [3:0] iack, pending;

   always #5 clk = ~clk;

   intr_ctrl #(.N_IRQ(4), .PC_W(10), .VEC_BASE(10'h3F0)) dut (
      .i_clk(clk), .i_reset(reset), .i_irq(irq), .i_ei(ei), .i_di(di), .i_reti(reti),
      .i_hold(hold), .i_mask_we(mask_we), .i_mask_wdata(mask_wdata),
      .o_take_int(take_int), .o_pc_vec(pc_vec), .o_int_push(int_push), .o_int_wesp(int_wesp),
      .o_iack(iack), .o_in_service(in_service), .o_pending(pending)
   );

   typedef struct {
      logic       rst;
      logic [3:0] irq;
      logic       ei, di, reti, hold, mwe;
      logic [3:0] mdata;
      logic       e_take;
      logic [9:0] e_pcv;
      logic [3:0] e_iack;
      logic       e_ins;
      logic [3:0] e_pend;
   } vec_t;

   vec_t vecs[$];
   vec_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic add(input logic r, input logic [3:0] q, input logic e, input logic d,
                      input logic rt, input logic h, input logic w, input logic [3:0] md,
                      input logic tk, input logic [9:0] pv, input logic [3:0] ak,
                      input logic is, input logic [3:0] pd);
      vec_t v;
      v.rst = r; v.irq = q; v.ei = e; v.di = d; v.reti = rt; v.hold = h; v.mwe = w;
      v.mdata = md; v.e_take = tk; v.e_pcv = pv; v.e_iack = ak; v.e_ins = is; v.e_pend = pd;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input int idx, input logic [31:0] act,
                      input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s vec %0d: got %0h expected %0h", name, idx, act, req);
      end
   endtask

   initial begin
      vec_t e;
      reset = 1'b1; irq = 4'b0000; ei = 1'b0; di = 1'b0; reti = 1'b0; hold = 1'b0;
      mask_we = 1'b0; mask_wdata = 4'b0000;

      //   rst  irq     ei   di   reti hold mwe  mdata   | take pc_vec  iack    ins  pending
      // reset, enable, single source 2
      add(1'b1,4'b0000,1'b0,1'b0,1'b0,1'b0,1'b0,4'b0000, 1'b0,10'h000,4'b0000,1'b0,4'b0000);
      add(1'b0,4'b0000,1'b1,1'b0,1'b0,1'b0,1'b1,4'b0000, 1'b0,10'h000,4'b0000,1'b0,4'b0000);
      add(1'b0,4'b0100,1'b0,1'b0,1'b0,1'b0,1'b0,4'b0000, 1'b0,10'h000,4'b0000,1'b0,4'b0100);
      add(1'b0,4'b0000,1'b0,1'b0,1'b0,1'b0,1'b0,4'b0000, 1'b1,10'h3F8,4'b0100,1'b1,4'b0000);
      add(1'b0,4'b0000,1'b0,1'b0,1'b0,1'b0,1'b0,4'b0000, 1'b0,10'h000,4'b0000,1'b1,4'b0000);
      add(1'b0,4'b0000,1'b0,1'b0,1'b0,1'b0,1'b0,4'b0000, 1'b0,10'h000,4'b0000,1'b1,4'b0000);
      add(1'b0,4'b0000,1'b0,1'b0,1'b1,1'b0,1'b0,4'b0000, 1'b0,10'h000,4'b0000,1'b0,4'b0000);
      // sources 1 and 3 together; held level must not re-pend source 1
      add(1'b0,4'b1010,1'b0,1'b0,1'b0,1'b0,1'b0,4'b0000, 1'b0,10'h000,4'b0000,1'b0,4'b1010);
      add(1'b0,4'b1010,1'b0,1'b0,1'b0,1'b0,1'b0,4'b0000, 1'b1,10'h3F4,4'b0010,1'b1,4'b1000);
      add(1'b0,4'b0000,1'b0,1'b0,1'b0,1'b0,1'b0,4'b0000, 1'b0,10'h000,4'b0000,1'b1,4'b1000);
      add(1'b0,4'b0000,1'b0,1'b0,1'b1,1'b0,1'b0,4'b0000, 1'b0,10'h000,4'b0000,1'b0,4'b1000);
      add(1'b0,4'b0000,1'b0,1'b0,1'b0,1'b0,1'b0,4'b0000, 1'b1,10'h3FC,4'b1000,1'b1,4'b0000);
      add(1'b0,4'b0000,1'b0,1'b0,1'b0,1'b0,1'b0,4'b0000, 1'b0,10'h000,4'b0000,1'b1,4'b0000);
      add(1'b0,4'b0000,1'b0,1'b0,1'b1,1'b0,1'b0,4'b0000, 1'b0,10'h000,4'b0000,1'b0,4'b0000);
      // gie off: pending held until ei
      add(1'b0,4'b0000,1'b0,1'b1,1'b0,1'b0,1'b0,4'b0000, 1'b0,10'h000,4'b0000,1'b0,4'b0000);
      add(1'b0,4'b0001,1'b0,1'b0,1'b0,1'b0,1'b0,4'b0000, 1'b0,10'h000,4'b0000,1'b0,4'b0001);
      add(1'b0,4'b0000,1'b0,1'b0,1'b0,1'b0,1'b0,4'b0000, 1'b0,10'h000,4'b0000,1'b0,4'b0001);
      add(1'b0,4'b0000,1'b0,1'b0,1'b0,1'b0,1'b0,4'b0000, 1'b0,10'h000,4'b0000,1'b0,4'b0001);
      add(1'b0,4'b0000,1'b1,1'b0,1'b0,1'b0,1'b0,4'b0000, 1'b0,10'h000,4'b0000,1'b0,4'b0001);
      add(1'b0,4'b0000,1'b0,1'b0,1'b0,1'b0,1'b0,4'b0000, 1'b1,10'h3F0,4'b0001,1'b1,4'b0000);
      add(1'b0,4'b0000,1'b0,1'b0,1'b0,1'b0,1'b0,4'b0000, 1'b0,10'h000,4'b0000,1'b1,4'b0000);
      add(1'b0,4'b0000,1'b0,1'b0,1'b1,1'b0,1'b0,4'b0000, 1'b0,10'h000,4'b0000,1'b0,4'b0000);
      // hold blocks entry; reti during ENTER is ignored
      add(1'b0,4'b0001,1'b0,1'b0,1'b0,1'b1,1'b0,4'b0000, 1'b0,10'h000,4'b0000,1'b0,4'b0001);
      add(1'b0,4'b0000,1'b0,1'b0,1'b0,1'b1,1'b0,4'b0000, 1'b0,10'h000,4'b0000,1'b0,4'b0001);
      add(1'b0,4'b0000,1'b0,1'b0,1'b0,1'b1,1'b0,4'b0000, 1'b0,10'h000,4'b0000,1'b0,4'b0001);
      add(1'b0,4'b0000,1'b0,1'b0,1'b0,1'b1,1'b0,4'b0000, 1'b0,10'h000,4'b0000,1'b0,4'b0001);
      add(1'b0,4'b0000,1'b0,1'b0,1'b0,1'b0,1'b0,4'b0000, 1'b1,10'h3F0,4'b0001,1'b1,4'b0000);
      add(1'b0,4'b0000,1'b0,1'b0,1'b1,1'b0,1'b0,4'b0000, 1'b0,10'h000,4'b0000,1'b1,4'b0000);
      add(1'b0,4'b0000,1'b0,1'b0,1'b0,1'b0,1'b0,4'b0000, 1'b0,10'h000,4'b0000,1'b1,4'b0000);
      add(1'b0,4'b0000,1'b0,1'b0,1'b1,1'b0,1'b0,4'b0000, 1'b0,10'h000,4'b0000,1'b0,4'b0000);
      // mask blocks source 0 without losing its pending bit
      add(1'b0,4'b0000,1'b0,1'b0,1'b0,1'b0,1'b1,4'b0001, 1'b0,10'h000,4'b0000,1'b0,4'b0000);
      add(1'b0,4'b0001,1'b0,1'b0,1'b0,1'b0,1'b0,4'b0000, 1'b0,10'h000,4'b0000,1'b0,4'b0001);
      add(1'b0,4'b0000,1'b0,1'b0,1'b0,1'b0,1'b0,4'b0000, 1'b0,10'h000,4'b0000,1'b0,4'b0001);
      add(1'b0,4'b0000,1'b0,1'b0,1'b0,1'b0,1'b0,4'b0000, 1'b0,10'h000,4'b0000,1'b0,4'b0001);
      add(1'b0,4'b0000,1'b0,1'b0,1'b0,1'b0,1'b1,4'b0000, 1'b0,10'h000,4'b0000,1'b0,4'b0001);
      add(1'b0,4'b0000,1'b0,1'b0,1'b0,1'b0,1'b0,4'b0000, 1'b1,10'h3F0,4'b0001,1'b1,4'b0000);
      add(1'b0,4'b0000,1'b0,1'b0,1'b0,1'b0,1'b0,4'b0000, 1'b0,10'h000,4'b0000,1'b1,4'b0000);
      add(1'b0,4'b0000,1'b0,1'b0,1'b1,1'b0,1'b0,4'b0000, 1'b0,10'h000,4'b0000,1'b0,4'b0000);
      // ei and di together leave gie clear
      add(1'b0,4'b0000,1'b1,1'b1,1'b0,1'b0,1'b0,4'b0000, 1'b0,10'h000,4'b0000,1'b0,4'b0000);
      add(1'b0,4'b0100,1'b0,1'b0,1'b0,1'b0,1'b0,4'b0000, 1'b0,10'h000,4'b0000,1'b0,4'b0100);
      add(1'b0,4'b0000,1'b0,1'b0,1'b0,1'b0,1'b0,4'b0000, 1'b0,10'h000,4'b0000,1'b0,4'b0100);
      add(1'b0,4'b0000,1'b0,1'b0,1'b0,1'b0,1'b0,4'b0000, 1'b0,10'h000,4'b0000,1'b0,4'b0100);
      add(1'b0,4'b0000,1'b1,1'b0,1'b0,1'b0,1'b0,4'b0000, 1'b0,10'h000,4'b0000,1'b0,4'b0100);
      add(1'b0,4'b0000,1'b0,1'b0,1'b0,1'b0,1'b0,4'b0000, 1'b1,10'h3F8,4'b0100,1'b1,4'b0000);
      add(1'b0,4'b0000,1'b0,1'b0,1'b0,1'b0,1'b0,4'b0000, 1'b0,10'h000,4'b0000,1'b1,4'b0000);
      add(1'b0,4'b0000,1'b0,1'b0,1'b1,1'b0,1'b0,4'b0000, 1'b0,10'h000,4'b0000,1'b0,4'b0000);
      // edge on source 1 latched during entry of source 0, then reset aborts service
      add(1'b0,4'b0001,1'b0,1'b0,1'b0,1'b0,1'b0,4'b0000, 1'b0,10'h000,4'b0000,1'b0,4'b0001);
      add(1'b0,4'b0010,1'b0,1'b0,1'b0,1'b0,1'b0,4'b0000, 1'b1,10'h3F0,4'b0001,1'b1,4'b0010);
      add(1'b0,4'b0000,1'b0,1'b0,1'b0,1'b0,1'b0,4'b0000, 1'b0,10'h000,4'b0000,1'b1,4'b0010);
      add(1'b1,4'b0000,1'b0,1'b0,1'b0,1'b0,1'b0,4'b0000, 1'b0,10'h000,4'b0000,1'b0,4'b0000);
      add(1'b0,4'b0000,1'b0,1'b0,1'b1,1'b0,1'b0,4'b0000, 1'b0,10'h000,4'b0000,1'b0,4'b0000);
      add(1'b0,4'b0000,1'b0,1'b0,1'b0,1'b0,1'b0,4'b0000, 1'b0,10'h000,4'b0000,1'b0,4'b0000);
      // new edge on the winner in the clear cycle keeps it pending; earliest re-entry
      add(1'b0,4'b0000,1'b1,1'b0,1'b0,1'b0,1'b0,4'b0000, 1'b0,10'h000,4'b0000,1'b0,4'b0000);
      add(1'b0,4'b0001,1'b0,1'b0,1'b0,1'b1,1'b0,4'b0000, 1'b0,10'h000,4'b0000,1'b0,4'b0001);
      add(1'b0,4'b0000,1'b0,1'b0,1'b0,1'b1,1'b0,4'b0000, 1'b0,10'h000,4'b0000,1'b0,4'b0001);
      add(1'b0,4'b0001,1'b0,1'b0,1'b0,1'b0,1'b0,4'b0000, 1'b1,10'h3F0,4'b0001,1'b1,4'b0001);
      add(1'b0,4'b0000,1'b0,1'b0,1'b0,1'b0,1'b0,4'b0000, 1'b0,10'h000,4'b0000,1'b1,4'b0001);
      add(1'b0,4'b0000,1'b0,1'b0,1'b1,1'b0,1'b0,4'b0000, 1'b0,10'h000,4'b0000,1'b0,4'b0001);
      add(1'b0,4'b0000,1'b0,1'b0,1'b0,1'b0,1'b0,4'b0000, 1'b1,10'h3F0,4'b0001,1'b1,4'b0000);
      add(1'b0,4'b0000,1'b0,1'b0,1'b0,1'b0,1'b0,4'b0000, 1'b0,10'h000,4'b0000,1'b1,4'b0000);
      add(1'b0,4'b0000,1'b0,1'b0,1'b1,1'b0,1'b0,4'b0000, 1'b0,10'h000,4'b0000,1'b0,4'b0000);

      for (int i = 0; i < vecs.size(); i++) begin
         reset = vecs[i].rst; irq = vecs[i].irq; ei = vecs[i].ei; di = vecs[i].di;
         reti = vecs[i].reti; hold = vecs[i].hold; mask_we = vecs[i].mwe;
         mask_wdata = vecs[i].mdata;
         exp_q.push_back(vecs[i]);
         @(posedge clk);
         #1;
         e = exp_q.pop_front();
         chk("take_int",   i, 32'(take_int),   32'(e.e_take));
         chk("int_push",   i, 32'(int_push),   32'(e.e_take));
         chk("int_wesp",   i, 32'(int_wesp),   32'(e.e_take));
         chk("pc_vec",     i, 32'(pc_vec),     32'(e.e_pcv));
         chk("iack",       i, 32'(iack),       32'(e.e_iack));
         chk("in_service", i, 32'(in_service), 32'(e.e_ins));
         chk("pending",    i, 32'(pending),    32'(e.e_pend));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
